// File: rtl/nvram_pkg.sv
// rtl/nvram_pkg.sv - shared FSM state type and fill constant for the NVRAM upload block
package nvram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } nvram_state_t;

  localparam logic [7:0] NVRAM_FILL = 8'hFF;

endpackage

// File: rtl/nvram_upload_if.sv
// rtl/nvram_upload_if.sv - HPS ioctl upload port and game-RAM read port bundle
interface nvram_upload_if #(
  parameter int AW = 10
);

  logic          ioctl_upload;
  logic [7:0]    ioctl_index;
  logic          ioctl_rd;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic          pause_req;
  logic          mem_grant;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [7:0]    mem_q;

  modport master (
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, mem_grant, mem_q,
    input  ioctl_din, ioctl_wait, pause_req, mem_addr, mem_rd
  );

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, mem_grant, mem_q,
    output ioctl_din, ioctl_wait, pause_req, mem_addr, mem_rd
  );

endinterface

// File: rtl/reset_sync.sv
// rtl/reset_sync.sv - asynchronous-assert, two-flop synchronous-deassert reset
module reset_sync (
  input  logic clk,
  input  logic rst_in_n,
  output logic rst_out_n
);

  logic meta;

  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      meta      <= 1'b0;
      rst_out_n <= 1'b0;
    end else begin
      meta      <= 1'b1;
      rst_out_n <= meta;
    end
  end

endmodule

// File: rtl/nvram_upload.sv
// rtl/nvram_upload.sv - serves HPS byte reads of a game-RAM image during an ioctl upload session
// Optional running checksum at address SIZE: define NVRAM_UPLOAD_CHECKSUM_EN.
module nvram_upload
  import nvram_pkg::*;
#(
  parameter int INDEX = 4,
  parameter int AW    = 10,
  parameter int SIZE  = 1024
) (
  input  logic           clk,
  input  logic           reset_n,
  nvram_upload_if.slave  bus
);

  localparam logic [24:0] SIZE_A  = 25'(SIZE);
  localparam logic [7:0]  INDEX_B = 8'(INDEX);

  logic          rst_n;
  logic          sel;
  logic          in_range;
  logic [7:0]    oor_data;
  logic [AW-1:0] addr_q;
  nvram_state_t  state;

  reset_sync u_reset_sync (
    .clk       (clk),
    .rst_in_n  (reset_n),
    .rst_out_n (rst_n)
  );

  assign sel          = bus.ioctl_upload && (bus.ioctl_index == INDEX_B);
  assign in_range     = bus.ioctl_addr < SIZE_A;
  assign bus.mem_addr = addr_q;

`ifdef NVRAM_UPLOAD_CHECKSUM_EN
  logic [7:0] sum;
  logic [AW:0] next_addr;

  assign oor_data = (bus.ioctl_addr == SIZE_A) ? (8'h00 - sum) : NVRAM_FILL;

  // pause_req is sel delayed one cycle, so it doubles as the session-start edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= 8'h00;
      next_addr <= '0;
    end else if (sel && !bus.pause_req) begin
      sum       <= 8'h00;
      next_addr <= '0;
    end else if (state == READ && sel && !bus.mem_rd && {1'b0, addr_q} == next_addr) begin
      sum       <= sum + bus.mem_q;
      next_addr <= next_addr + (AW+1)'(1);
    end
  end
`else
  assign oor_data = NVRAM_FILL;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      addr_q         <= '0;
      bus.ioctl_din  <= 8'h00;
      bus.ioctl_wait <= 1'b0;
      bus.pause_req  <= 1'b0;
      bus.mem_rd     <= 1'b0;
    end else begin
      bus.pause_req <= sel;
      bus.mem_rd    <= 1'b0;
      case (state)
        IDLE: begin
          if (sel && bus.ioctl_rd) begin
            if (in_range) begin
              addr_q         <= bus.ioctl_addr[AW-1:0];
              bus.ioctl_wait <= 1'b1;
              state          <= ARB;
            end else begin
              bus.ioctl_din <= oor_data;
            end
          end
        end
        ARB: begin
          if (!sel) begin
            bus.ioctl_wait <= 1'b0;
            state          <= IDLE;
          end else if (bus.mem_grant) begin
            bus.mem_rd <= 1'b1;
            state      <= READ;
          end
        end
        READ: begin
          // first READ cycle carries the mem_rd pulse; mem_q is valid the cycle after
          if (!sel) begin
            bus.ioctl_wait <= 1'b0;
            state          <= IDLE;
          end else if (!bus.mem_rd) begin
            bus.ioctl_din  <= bus.mem_q;
            bus.ioctl_wait <= 1'b0;
            state          <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/nvram_upload.md
NVRAM_UPLOAD -- requirements
Module: nvram_upload

Interface
REQ-001 SHALL have parameter INDEX, default 4: ioctl_index value this block serves.
REQ-002 SHALL have parameter AW, default 10: game-RAM address width.
REQ-003 SHALL have parameter SIZE, default 1024: image length in bytes, at most 2^AW.
REQ-004 SHALL have ports, one per line:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- ioctl_upload  in  1  HPS upload session active.
- ioctl_index  in  8  selected image index.
- ioctl_rd  in  1  one-cycle byte read strobe.
- ioctl_addr  in  25  byte address of the read.
- ioctl_din  out  8  byte returned to HPS.
- ioctl_wait  out  1  stall to HPS while a fetch is pending.
- pause_req  out  1  request to the game to release its RAM port.
- mem_grant  in  1  game RAM port is free this cycle.
- mem_addr  out  AW  game RAM read address.
- mem_rd  out  1  one-cycle read strobe.
- mem_q  in  8  read data, valid 1 cycle after mem_rd.

Function
REQ-005 SHALL be active (sel=1) only while ioctl_upload=1 and ioctl_index==INDEX; otherwise ioctl_rd SHALL be ignored.
REQ-006 SHALL drive pause_req=1 for the whole time sel=1, registered, with 1-cycle latency.
REQ-007 SHALL implement the FSM IDLE, ARB, READ, DONE.
REQ-008 In IDLE, when sel and ioctl_rd occur with ioctl_addr<SIZE: latch addr[AW-1:0], set ioctl_wait=1 on the next cycle, and go to ARB.
REQ-009 In ARB, when mem_grant=1: pulse mem_rd for 1 cycle with mem_addr=latched address, and go to READ; otherwise remain in ARB with no timeout.
REQ-010 In READ: capture mem_q into ioctl_din, clear ioctl_wait, and go to DONE.
REQ-011 DONE SHALL return to IDLE on the next cycle.
REQ-012 Latency from ioctl_rd to ioctl_wait=0 SHALL be 4 cycles when mem_grant is held high.
REQ-013 When ioctl_addr>=SIZE (and the checksum slot of REQ-023 does not apply): SHALL set ioctl_din=8'hFF on the next cycle, leave ioctl_wait at 0, and issue no memory access.
REQ-014 ioctl_rd arriving while not in IDLE SHALL be ignored; HPS honours ioctl_wait.
REQ-015 ioctl_din SHALL hold its last value between reads.
REQ-016 If sel drops mid-fetch: abort to IDLE, clear ioctl_wait the next cycle, and produce no further mem_rd. A grant already issued completes silently.
REQ-017 mem_rd SHALL never be asserted unless mem_grant=1 in that same cycle.

Reset
REQ-018 reset_n=0 SHALL asynchronously force: FSM=IDLE, ioctl_din=8'h00, ioctl_wait=0, pause_req=0, mem_rd=0, mem_addr=0, checksum=0.
REQ-019 Release of reset_n SHALL be synchronised internally with a 2-flop deassertion chain.

Configuration
REQ-020 With macro NVRAM_UPLOAD_CHECKSUM_EN defined, the block SHALL keep an 8-bit running sum (mod 256) of every byte returned for addresses 0..SIZE-1.
REQ-021 The sum SHALL clear on each rising edge of sel.
REQ-022 The sum SHALL accumulate only on the first read of each address, tracked by next-expected-address compare.
REQ-023 A read at ioctl_addr==SIZE SHALL return the two's complement of the sum, with no memory access and no wait.
REQ-024 Without the macro, address SIZE SHALL return 8'hFF per REQ-013, and the sum logic SHALL be absent.

Structure
REQ-025 Shared package nvram_pkg SHALL hold the FSM state enum (IDLE, ARB, READ, DONE) and constant NVRAM_FILL=8'hFF.
REQ-026 Deassertion synchroniser SHALL be sub-module reset_sync.
REQ-027 No other sub-modules.

Verification
REQ-028 Upload session, index 4, mem_grant=1, RAM[0x010]=8'h5A, ioctl_rd addr 0x010 -> ioctl_wait high for 3 cycles, mem_rd once with mem_addr=0x010, ioctl_din=8'h5A.
REQ-029 mem_grant held 0 for 20 cycles after ioctl_rd addr 0x3FF -> no mem_rd, ioctl_wait stays 1. Grant raised -> single mem_rd, correct byte, wait drops.
REQ-030 ioctl_rd addr 0x500, SIZE=1024 -> ioctl_din=8'hFF next cycle, ioctl_wait never 1, no mem_rd.
REQ-031 ioctl_upload dropped while in ARB -> FSM IDLE, ioctl_wait 0 next cycle, pause_req 0 one cycle later, no mem_rd.
REQ-032 CHECKSUM_EN, RAM filled 8'h01, read 0..1023 then addr 1024 -> returns 8'h00. Fill 8'h03 -> returns 8'h00. Bytes 8'h01 except RAM[0]=8'h02 -> returns 8'hFF.
REQ-033 reset_n pulsed low during READ -> all outputs at reset values immediately; next ioctl_rd serviced normally.
